deskew_sched: RTL and testbench
===============================

Name: deskew_sched

Overview:
Sequencer and memory-port arbiter for the deskew engine. Owns the single image BRAM port (2048 x WIDTH; input image at 0..783, deskewed output at 784..1567). Lets the host load pixels and read results, launches the engine with a one-cycle start pulse, and hands the BRAM port to the engine for the whole run. Reports busy/done/error status and an image counter to the host.

Parameters:
WIDTH, 16, BRAM data width
ADDR_W, 11, BRAM address width
MAX_WAIT, 8, cycles allowed for ds_ready to fall after ds_start before error
CNT_W, 16, width of img_cnt and cycle counter

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
host_start  in  1  request a deskew run
host_ack  in  1  acknowledge done/error, return to idle
busy  out  1  engine running or not yet ready
done  out  1  run finished, results readable
err  out  1  engine failed to acknowledge start
img_cnt  out  CNT_W  completed runs, wraps
h_address  in  ADDR_W  host BRAM address
h_wdata  in  WIDTH  host write data
h_en  in  1  host BRAM enable
h_we  in  1  host write enable
h_gnt  out  1  host currently owns BRAM port
h_rdata  out  WIDTH  host read data (= mem_rdata)
h_rvalid  out  1  h_rdata valid
ds_start  out  1  engine start pulse
ds_ready  in  1  engine idle/ready
ds_address  in  ADDR_W  engine BRAM address
ds_out_data  in  WIDTH  engine write data
ds_en  in  1  engine BRAM enable
ds_we  in  1  engine write enable
ds_in_data  out  WIDTH  read data to engine (= mem_rdata)
mem_address  out  ADDR_W  BRAM address
mem_wdata  out  WIDTH  BRAM write data
mem_en  out  1  BRAM enable
mem_we  out  1  BRAM write enable
mem_rdata  in  WIDTH  BRAM read data, 1-cycle latency

Behaviour:
- Reset (reset=0, async): state=IDLE; ds_start, done, err, h_rvalid=0; wait counter and img_cnt=0.
- States: IDLE, KICK, ACK_WAIT, RUN, DONE, ERR.
- IDLE: host owns port. host_start=1 and ds_ready=1 -> KICK. host_start with ds_ready=0 is ignored, with no latching.
- KICK: ds_start=1 for exactly this cycle; engine owns port; wait counter cleared -> ACK_WAIT.
- ACK_WAIT: engine owns port. ds_ready=0 -> RUN. Otherwise increment counter; counter reaching MAX_WAIT-1 with ds_ready still 1 -> ERR.
- RUN: engine owns port. ds_ready=1 -> DONE, with img_cnt+1 (modulo 2^CNT_W).
- DONE: done=1; host owns port. host_start=1 and ds_ready=1 -> KICK (start wins over a simultaneous host_ack). Otherwise host_ack=1 -> IDLE.
- ERR: err=1; host owns port. host_ack=1 -> IDLE. host_start is ignored.
- h_gnt=1 in IDLE, DONE and ERR; 0 otherwise.
- busy=1 in KICK, ACK_WAIT and RUN; in IDLE/DONE it follows !ds_ready.
- mem_* is a combinational mux: h_gnt ? host signals : engine signals. Host h_en/h_we with h_gnt=0 are dropped, never queued; the host must hold the request.
- h_rvalid is a register set to (h_en & !h_we & h_gnt) of the previous cycle.
- ds_in_data=h_rdata=mem_rdata unconditionally.
- The engine is never granted outside KICK/ACK_WAIT/RUN; its signals are ignored there.
- Reset mid-run: the scheduler returns to IDLE, and the next start is held off until ds_ready=1.

Optional Feature:
DESKEW_SCHED_PERF_EN
- Defined: adds output run_cycles[CNT_W-1:0]. Counter cleared in KICK, increments every cycle in ACK_WAIT and RUN (saturating at all-ones), frozen in DONE and ERR. Reset value 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Host write/read in IDLE: write 0x00FF to address 5, then read address 5 -> mem_we=1 the write cycle; h_rvalid=1 with h_rdata=0x00FF one cycle after the read.
- Normal run: host_start with engine model dropping ds_ready 1 cycle after ds_start, then busy for 100 cycles -> ds_start is a single-cycle pulse; h_gnt=0 for exactly 102 cycles; done=1; img_cnt=1.
- Host access during RUN: h_en=1, h_we=1 to address 800 -> mem_we follows ds_we only; h_rvalid stays 0; BRAM address 800 holds the engine value.
- Start timeout with MAX_WAIT=8 and ds_ready stuck at 1 -> err=1 exactly 9 cycles after the KICK cycle; host_ack -> IDLE, err=0.
- DONE with host_start and host_ack asserted together -> next state KICK and a second ds_start pulse; img_cnt=2 after the run.
- Assert reset low in RUN, engine keeps ds_ready=0 -> IDLE with all outputs at reset values; host_start is ignored until ds_ready=1; with PERF_EN, run_cycles=0.

Source files
------------

// File: rtl/deskew_sched.sv
// deskew_sched: sequencer and BRAM-port arbiter for the deskew engine.
// The host owns the single image BRAM port while idle, done or in error.
// A host start launches the engine with a one-cycle ds_start pulse. The
// engine then owns the port until it signals ready again.
// Ports:
//   clk, reset (async, active-low)
//   host_start/host_ack                host control
//   busy/done/err/img_cnt              host status
//   h_address/h_wdata/h_en/h_we        host BRAM request
//   h_gnt/h_rdata/h_rvalid             host grant and read data
//   ds_start/ds_ready                  engine handshake
//   ds_address/ds_out_data/ds_en/ds_we engine BRAM request
//   ds_in_data                         engine read data
//   mem_address/mem_wdata/mem_en/mem_we/mem_rdata  BRAM port
// Optional: define DESKEW_SCHED_PERF_EN to add the run_cycles output.
module deskew_sched #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned MAX_WAIT = 8,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_start,
  input  logic              host_ack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  img_cnt,
  input  logic [ADDR_W-1:0] h_address,
  input  logic [WIDTH-1:0]  h_wdata,
  input  logic              h_en,
  input  logic              h_we,
  output logic              h_gnt,
  output logic [WIDTH-1:0]  h_rdata,
  output logic              h_rvalid,
  output logic              ds_start,
  input  logic              ds_ready,
  input  logic [ADDR_W-1:0] ds_address,
  input  logic [WIDTH-1:0]  ds_out_data,
  input  logic              ds_en,
  input  logic              ds_we,
  output logic [WIDTH-1:0]  ds_in_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              mem_en,
  output logic              mem_we,
  input  logic [WIDTH-1:0]  mem_rdata
`ifdef DESKEW_SCHED_PERF_EN
  ,
  output logic [CNT_W-1:0]  run_cycles
`endif
);

  localparam int unsigned     WAIT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_KICK     = 3'd1,
    S_ACK_WAIT = 3'd2,
    S_RUN      = 3'd3,
    S_DONE     = 3'd4,
    S_ERR      = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [WAIT_W-1:0]  w_wait_nxt;
  logic [CNT_W-1:0]   r_img_cnt;
  logic [CNT_W-1:0]   w_img_nxt;
  logic               r_ds_start;
  logic               r_done;
  logic               r_err;
  logic               r_h_gnt;
  logic               r_eng;        // engine phase: KICK, ACK_WAIT or RUN
  logic               r_follow;     // IDLE or DONE: busy mirrors !ds_ready
  logic               r_h_rvalid;
  logic               w_ds_start_nxt;
  logic               w_done_nxt;
  logic               w_err_nxt;
  logic               w_gnt_nxt;
  logic               w_eng_nxt;
  logic               w_follow_nxt;

  // Next-state logic plus decode of the registered Moore outputs
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_img_nxt   = r_img_cnt;
    case (r_state)
      S_IDLE: begin
        if (host_start && ds_ready) w_state_nxt = S_KICK;
      end
      S_KICK: begin
        w_wait_nxt  = '0;
        w_state_nxt = S_ACK_WAIT;
      end
      S_ACK_WAIT: begin
        if (!ds_ready)                    w_state_nxt = S_RUN;
        else if (r_wait_cnt == WAIT_LAST) w_state_nxt = S_ERR;
        else                              w_wait_nxt  = r_wait_cnt + WAIT_W'(1);
      end
      S_RUN: begin
        if (ds_ready) begin
          w_state_nxt = S_DONE;
          w_img_nxt   = r_img_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        // A new start takes priority over a simultaneous acknowledge
        if (host_start && ds_ready) w_state_nxt = S_KICK;
        else if (host_ack)          w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        if (host_ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_ds_start_nxt = (w_state_nxt == S_KICK);
    w_done_nxt     = (w_state_nxt == S_DONE);
    w_err_nxt      = (w_state_nxt == S_ERR);
    w_gnt_nxt      = (w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE) ||
                     (w_state_nxt == S_ERR);
    w_eng_nxt      = (w_state_nxt == S_KICK) || (w_state_nxt == S_ACK_WAIT) ||
                     (w_state_nxt == S_RUN);
    w_follow_nxt   = (w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE);
  end

  // State register and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_img_cnt  <= '0;
      r_ds_start <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_h_gnt    <= 1'b1;
      r_eng      <= 1'b0;
      r_follow   <= 1'b1;
      r_h_rvalid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_img_cnt  <= w_img_nxt;
      r_ds_start <= w_ds_start_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_h_gnt    <= w_gnt_nxt;
      r_eng      <= w_eng_nxt;
      r_follow   <= w_follow_nxt;
      r_h_rvalid <= h_en & ~h_we & r_h_gnt;
    end
  end

`ifdef DESKEW_SCHED_PERF_EN
  logic [CNT_W-1:0] r_run_cycles;

  // Run length: cleared on launch, saturating count while the engine owns the port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run_cycles <= '0;
    end else begin
      case (r_state)
        S_KICK:            r_run_cycles <= '0;
        S_ACK_WAIT, S_RUN: if (r_run_cycles != '1) r_run_cycles <= r_run_cycles + CNT_W'(1);
        default:           r_run_cycles <= r_run_cycles;
      endcase
    end
  end

  assign run_cycles = r_run_cycles;
`endif

  // BRAM port mux; host requests without grant are simply dropped
  assign mem_address = r_h_gnt ? h_address : ds_address;
  assign mem_wdata   = r_h_gnt ? h_wdata   : ds_out_data;
  assign mem_en      = r_h_gnt ? h_en      : ds_en;
  assign mem_we      = r_h_gnt ? h_we      : ds_we;

  assign h_rdata    = mem_rdata;
  assign ds_in_data = mem_rdata;
  assign h_rvalid   = r_h_rvalid;
  assign h_gnt      = r_h_gnt;
  assign ds_start   = r_ds_start;
  assign done       = r_done;
  assign err        = r_err;
  assign img_cnt    = r_img_cnt;
  assign busy       = r_eng | (r_follow & ~ds_ready);

endmodule

// File: tb/tb_deskew_sched.sv
// tb_deskew_sched: directed bench for deskew_sched with a cycle-level
// behavioural model, a per-cycle compare process and a BRAM model.
module tb_deskew_sched;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned ADDR_W   = 11;
  localparam int unsigned MAX_WAIT = 8;
  localparam int unsigned CNT_W    = 16;

  localparam int P_IDLE  = 0;
  localparam int P_KICK  = 1;
  localparam int P_AWAIT = 2;
  localparam int P_RUN   = 3;
  localparam int P_DONE  = 4;
  localparam int P_ERR   = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              host_start = 1'b0;
  logic              host_ack = 1'b0;
  logic              busy, done, err;
  logic [CNT_W-1:0]  img_cnt;
  logic [ADDR_W-1:0] h_address = '0;
  logic [WIDTH-1:0]  h_wdata = '0;
  logic              h_en = 1'b0;
  logic              h_we = 1'b0;
  logic              h_gnt;
  logic [WIDTH-1:0]  h_rdata;
  logic              h_rvalid;
  logic              ds_start;
  logic              ds_ready = 1'b1;
  logic [ADDR_W-1:0] ds_address = '0;
  logic [WIDTH-1:0]  ds_out_data = '0;
  logic              ds_en = 1'b0;
  logic              ds_we = 1'b0;
  logic [WIDTH-1:0]  ds_in_data;
  logic [ADDR_W-1:0] mem_address;
  logic [WIDTH-1:0]  mem_wdata;
  logic              mem_en, mem_we;
  logic [WIDTH-1:0]  mem_rdata = '0;
`ifdef DESKEW_SCHED_PERF_EN
  logic [CNT_W-1:0]  run_cycles;
`endif

  deskew_sched #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .host_start(host_start), .host_ack(host_ack),
    .busy(busy), .done(done), .err(err), .img_cnt(img_cnt),
    .h_address(h_address), .h_wdata(h_wdata), .h_en(h_en), .h_we(h_we),
    .h_gnt(h_gnt), .h_rdata(h_rdata), .h_rvalid(h_rvalid),
    .ds_start(ds_start), .ds_ready(ds_ready), .ds_address(ds_address),
    .ds_out_data(ds_out_data), .ds_en(ds_en), .ds_we(ds_we), .ds_in_data(ds_in_data),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
`ifdef DESKEW_SCHED_PERF_EN
    , .run_cycles(run_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Image BRAM: read-first, one-cycle read latency
  logic [WIDTH-1:0] bram [0:2047];
  initial for (int i = 0; i < 2048; i++) bram[i] = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_address] <= mem_wdata;
      mem_rdata <= bram[mem_address];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: who owns the port and what the host should see
  int          m_phase  = P_IDLE;
  int          m_age    = 0;       // ACK_WAIT cycles spent with the engine still ready
  logic [15:0] m_img    = '0;
  logic        m_rvalid = 1'b0;
  logic [15:0] m_perf   = '0;

  function automatic logic host_owns(input int p);
    return (p == P_IDLE) || (p == P_DONE) || (p == P_ERR);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase  = P_IDLE;
      m_age    = 0;
      m_img    = '0;
      m_rvalid = 1'b0;
      m_perf   = '0;
    end else begin
      m_rvalid = h_en && !h_we && host_owns(m_phase);
      case (m_phase)
        P_IDLE: if (host_start && ds_ready) m_phase = P_KICK;
        P_KICK: begin
          m_age   = 0;
          m_perf  = '0;
          m_phase = P_AWAIT;
        end
        P_AWAIT: begin
          if (m_perf != 16'hFFFF) m_perf = m_perf + 16'd1;
          if (!ds_ready) m_phase = P_RUN;
          else begin
            m_age = m_age + 1;
            if (m_age == int'(MAX_WAIT)) m_phase = P_ERR;
          end
        end
        P_RUN: begin
          if (m_perf != 16'hFFFF) m_perf = m_perf + 16'd1;
          if (ds_ready) begin
            m_phase = P_DONE;
            m_img   = m_img + 16'd1;
          end
        end
        P_DONE: begin
          if (host_start && ds_ready) m_phase = P_KICK;
          else if (host_ack)          m_phase = P_IDLE;
        end
        P_ERR: if (host_ack) m_phase = P_IDLE;
        default: m_phase = P_IDLE;
      endcase
    end
  end

  // Per-cycle compare against the model, away from the active edge
  bit chk_on  = 1'b1;
  int g0_cnt  = 0;
  int st_cnt  = 0;
  always @(negedge clk) begin
    if (chk_on) begin
      logic g;
      g = host_owns(m_phase);
      chk("ds_start", 32'(ds_start), 32'(m_phase == P_KICK));
      chk("done", 32'(done), 32'(m_phase == P_DONE));
      chk("err", 32'(err), 32'(m_phase == P_ERR));
      chk("h_gnt", 32'(h_gnt), 32'(g));
      if (m_phase != P_ERR)
        chk("busy", 32'(busy), (m_phase == P_IDLE || m_phase == P_DONE) ? 32'(!ds_ready) : 32'd1);
      chk("img_cnt", 32'(img_cnt), 32'(m_img));
      chk("h_rvalid", 32'(h_rvalid), 32'(m_rvalid));
      chk("mem_en", 32'(mem_en), 32'(g ? h_en : ds_en));
      chk("mem_we", 32'(mem_we), 32'(g ? h_we : ds_we));
      chk("mem_address", 32'(mem_address), 32'(g ? h_address : ds_address));
      chk("mem_wdata", 32'(mem_wdata), 32'(g ? h_wdata : ds_out_data));
      chk("h_rdata", 32'(h_rdata), 32'(mem_rdata));
      chk("ds_in_data", 32'(ds_in_data), 32'(mem_rdata));
`ifdef DESKEW_SCHED_PERF_EN
      chk("run_cycles", 32'(run_cycles), 32'(m_perf));
`endif
      if (!h_gnt) g0_cnt++;
      if (ds_start) st_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bus();
    h_en = 1'b0; h_we = 1'b0; h_address = '0; h_wdata = '0;
    ds_en = 1'b0; ds_we = 1'b0; ds_address = '0; ds_out_data = '0;
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    chk("rst_gnt", 32'(h_gnt), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_img", 32'(img_cnt), 32'd0);
    chk("rst_start", 32'(ds_start), 32'd0);
    step();
    reset = 1'b1;
    step();

    // Host write then read in IDLE
    h_en = 1'b1; h_we = 1'b1; h_address = 11'd5; h_wdata = 16'h00FF;
    @(negedge clk);
    chk("wr_we", 32'(mem_we), 32'd1);
    chk("wr_addr", 32'(mem_address), 32'd5);
    step();
    h_we = 1'b0;
    step();
    clear_bus();
    @(negedge clk);
    chk("rd_valid", 32'(h_rvalid), 32'd1);
    chk("rd_data", 32'(h_rdata), 32'h00FF);

    // Normal run: engine busy for 100 cycles
    step();
    g0_cnt = 0; st_cnt = 0;
    host_start = 1'b1;
    step();
    host_start = 1'b0;
    @(negedge clk);
    chk("kick_pulse", 32'(ds_start), 32'd1);
    chk("kick_gnt", 32'(h_gnt), 32'd0);
    step();
    ds_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      clear_bus();
      if (i == 50) begin
        ds_en = 1'b1; ds_we = 1'b1; ds_address = 11'd800; ds_out_data = 16'h1234;
        h_en = 1'b1; h_we = 1'b1; h_address = 11'd800; h_wdata = 16'hBEEF;
      end else if (i == 51) begin
        h_en = 1'b1; h_we = 1'b1; h_address = 11'd800; h_wdata = 16'hBEEF;
      end else if (i == 52) begin
        h_en = 1'b1; h_address = 11'd800;
      end
      @(negedge clk);
      if (i == 50) begin
        chk("run_eng_we", 32'(mem_we), 32'd1);
        chk("run_eng_wdata", 32'(mem_wdata), 32'h1234);
        chk("run_eng_addr", 32'(mem_address), 32'd800);
      end
      if (i == 51) chk("run_host_we_dropped", 32'(mem_we), 32'd0);
      if (i == 53) chk("run_no_rvalid", 32'(h_rvalid), 32'd0);
      step();
    end
    clear_bus();
    ds_ready = 1'b1;
    step();
    @(negedge clk);
    chk("run1_done", 32'(done), 32'd1);
    chk("run1_img", 32'(img_cnt), 32'd1);
    chk("run1_gnt_low_cycles", 32'(g0_cnt), 32'd102);
    chk("run1_start_pulses", 32'(st_cnt), 32'd1);
`ifdef DESKEW_SCHED_PERF_EN
    chk("run1_cycles", 32'(run_cycles), 32'd101);
`endif
    // Engine value at 800 survived the dropped host write
    step();
    h_en = 1'b1; h_address = 11'd800;
    step();
    clear_bus();
    @(negedge clk);
    chk("rd800_valid", 32'(h_rvalid), 32'd1);
    chk("rd800_data", 32'(h_rdata), 32'h1234);

    // DONE with start and ack together relaunches
    host_start = 1'b1; host_ack = 1'b1;
    step();
    host_start = 1'b0; host_ack = 1'b0;
    @(negedge clk);
    chk("kick2_pulse", 32'(ds_start), 32'd1);
    step();
    ds_ready = 1'b0;
    step();
    step();
    ds_ready = 1'b1;
    step();
    @(negedge clk);
    chk("run2_done", 32'(done), 32'd1);
    chk("run2_img", 32'(img_cnt), 32'd2);
    host_ack = 1'b1;
    step();
    host_ack = 1'b0;
    @(negedge clk);
    chk("ack_idle_gnt", 32'(h_gnt), 32'd1);
    chk("ack_idle_done", 32'(done), 32'd0);

    // Start timeout: engine never drops ready
    step();
    host_start = 1'b1;
    step();
    host_start = 1'b0;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      chk($sformatf("timeout_err_c%0d", c), 32'(err), (c == 9) ? 32'd1 : 32'd0);
      step();
    end
`ifdef DESKEW_SCHED_PERF_EN
    chk("timeout_cycles", 32'(run_cycles), 32'd8);
`endif
    host_start = 1'b1;
    step();
    host_start = 1'b0;
    @(negedge clk);
    chk("err_ignores_start", 32'(err), 32'd1);
    host_ack = 1'b1;
    step();
    host_ack = 1'b0;
    @(negedge clk);
    chk("err_cleared", 32'(err), 32'd0);
    chk("err_ack_gnt", 32'(h_gnt), 32'd1);
    chk("err_img_kept", 32'(img_cnt), 32'd2);

    // Reset in RUN while the engine stays busy
    step();
    host_start = 1'b1;
    step();
    host_start = 1'b0;
    step();
    ds_ready = 1'b0;
    repeat (5) step();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_gnt", 32'(h_gnt), 32'd1);
    chk("mid_rst_start", 32'(ds_start), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_img", 32'(img_cnt), 32'd0);
    chk("mid_rst_rvalid", 32'(h_rvalid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd1);
`ifdef DESKEW_SCHED_PERF_EN
    chk("mid_rst_cycles", 32'(run_cycles), 32'd0);
`endif
    step();
    reset = 1'b1;
    host_start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("held_off_start", 32'(ds_start), 32'd0);
      step();
    end
    ds_ready = 1'b1;
    step();
    host_start = 1'b0;
    @(negedge clk);
    chk("released_kick", 32'(ds_start), 32'd1);
    repeat (3) step();

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
